// File: rtl/mul_div.sv
// mul_div_issue: issue/hold stage in front of the combinational mul_div unit.
// It accepts one M-extension op, holds the operands on md_* for N cycles so the
// divider can be timed as a multicycle path, then captures md_res and presents
// it to writeback together with its destination tag.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no op in flight, ready to accept
//   EXEC  | operands and op held on md_*, cnt counts down to the sample cycle
//   DONE  | result captured in res_q, wb_valid high until writeback takes it
module mul_div_issue #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4,
    parameter int RD_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic [31:0]     md_a,
    output logic [31:0]     md_b,
    output logic [3:0]      md_op,
    input  logic [31:0]     md_res,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       a_q, b_q, res_q;
    logic [3:0]        op_q;
    logic [RD_W-1:0]   rd_q;
    logic [CNT_W-1:0]  cnt_q;

    logic op_legal;
    logic accept;
    logic issue;

    // Decode of the legal op encodings; anything else is consumed as a no_op.
    always_comb begin
        op_legal = 1'b0;
        case (in_op)
            4'b0011, 4'b0101, 4'b0111, 4'b0110,
            4'b1001, 4'b1011, 4'b1101, 4'b1111: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // in_ready only looks at state, wb_ready, flush and rst, never at the op itself.
    assign in_ready = !rst && !flush &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && wb_ready));
    assign accept   = in_valid && in_ready;
    assign issue    = accept && op_legal;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything except reset.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (issue) state_d = S_EXEC;
                S_EXEC: if (cnt_q == '0) state_d = S_DONE;
                S_DONE: if (wb_ready) state_d = issue ? S_EXEC : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Operand capture, hold counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else if (issue) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            rd_q  <= in_rd;
            cnt_q <= in_op[3] ? DIV_LOAD : MUL_LOAD;
        end else if (state_q == S_EXEC) begin
            if (cnt_q == '0) begin
                res_q <= md_res;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Outputs come from registers and state only; rst forces them quiet at once.
    always_comb begin
        md_a     = a_q;
        md_b     = b_q;
        md_op    = (state_q == S_EXEC) ? op_q : 4'b0000;
        wb_valid = (state_q == S_DONE);
        wb_data  = res_q;
        wb_rd    = rd_q;
        busy     = (state_q != S_IDLE);
        if (rst) begin
            md_a     = '0;
            md_b     = '0;
            md_op    = 4'b0000;
            wb_valid = 1'b0;
            wb_data  = '0;
            wb_rd    = '0;
            busy     = 1'b0;
        end
    end

endmodule
